// File: rtl/beat_pkg.sv
// Shared definitions for the SSEM beat sequencer: default beat geometry,
// stage and run-state encodings.
package beat_pkg;

    localparam int DEF_WORD_BITS     = 32;
    localparam int DEF_BLACKOUT_BITS = 4;

    function automatic int beatLen(input int wordBits, input int blackoutBits);
        return wordBits + blackoutBits;
    endfunction

    localparam int DEF_BEAT_LEN = beatLen(DEF_WORD_BITS, DEF_BLACKOUT_BITS);
    localparam int DEF_DIGIT_W  = $clog2(DEF_BEAT_LEN);

    typedef enum logic [1:0] {
        SCAN1   = 2'd0,
        ACTION1 = 2'd1,
        SCAN2   = 2'd2,
        ACTION2 = 2'd3
    } stage_t;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        SINGLE  = 2'd2
    } run_t;

endpackage

// File: rtl/beat_sequencer_if.sv
// Control-panel and waveform bundle of the beat sequencer. The master side is
// the operator/staticisor, the slave side is the sequencer itself.
interface beat_sequencer_if
    import beat_pkg::*;
#(
    parameter int DIGIT_W = DEF_DIGIT_W
);

    logic               w_RUN_SWITCH;
    logic               w_KC;
    logic               w_STOP_INSTR;
    logic [DIGIT_W-1:0] w_DIGIT;
    logic               w_BLACKOUT;
    logic [1:0]         w_STAGE;
    logic               w_PARA_ACTION_WF;
    logic               w_ACTION_PARA_WF;
    logic               w_INSTR_GATE;
    logic               w_ACTION_TRIGGER;
    logic               w_RUNNING;

    modport master (
        output w_RUN_SWITCH, w_KC, w_STOP_INSTR,
        input  w_DIGIT, w_BLACKOUT, w_STAGE, w_PARA_ACTION_WF, w_ACTION_PARA_WF,
               w_INSTR_GATE, w_ACTION_TRIGGER, w_RUNNING
    );

    modport slave (
        input  w_RUN_SWITCH, w_KC, w_STOP_INSTR,
        output w_DIGIT, w_BLACKOUT, w_STAGE, w_PARA_ACTION_WF, w_ACTION_PARA_WF,
               w_INSTR_GATE, w_ACTION_TRIGGER, w_RUNNING
    );

endinterface

// File: rtl/digit_counter.sv
// Free-running modulo-BEAT_LEN digit counter; flags the blackout digits and
// the last digit of the beat (the beat boundary).
module digit_counter
    import beat_pkg::*;
#(
    parameter  int WORD_BITS     = DEF_WORD_BITS,
    parameter  int BLACKOUT_BITS = DEF_BLACKOUT_BITS,
    localparam int BEAT_LEN      = beatLen(WORD_BITS, BLACKOUT_BITS),
    localparam int DIGIT_W       = $clog2(BEAT_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_blackout,
    output logic               o_boundary
);

    logic [DIGIT_W-1:0] r_count;
    logic               w_atEnd;

    assign w_atEnd = (r_count == DIGIT_W'(BEAT_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_atEnd) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + DIGIT_W'(1);
        end
    end

    assign o_digit    = r_count;
    assign o_blackout = (r_count >= DIGIT_W'(WORD_BITS));
    assign o_boundary = w_atEnd;

endmodule

// File: rtl/beat_sequencer.sv
// SSEM master timing: steps each instruction through SCAN1/ACTION1/SCAN2/ACTION2,
// handles stop/run, single-shot (KC) and halting on a decoded STOP instruction.
module beat_sequencer
    import beat_pkg::*;
#(
    parameter int WORD_BITS     = DEF_WORD_BITS,
    parameter int BLACKOUT_BITS = DEF_BLACKOUT_BITS
) (
    input  logic            w_CLK,
    input  logic            w_RST,
    beat_sequencer_if.slave bus
);

    localparam int BEAT_LEN = beatLen(WORD_BITS, BLACKOUT_BITS);
    localparam int DIGIT_W  = $clog2(BEAT_LEN);

    logic [DIGIT_W-1:0] w_digit;
    logic               w_blackout;
    logic               w_boundary;

    run_t   r_state, w_stateNext;
    stage_t r_stage, w_stageNext;
    logic   r_halt, w_haltNext;
    logic   r_pend, w_pendNext;
    logic   r_kcPrev;
    logic   w_kcRise;
    logic   w_instrEnd;

    digit_counter #(
        .WORD_BITS     (WORD_BITS),
        .BLACKOUT_BITS (BLACKOUT_BITS)
    ) u_digitCounter (
        .clk        (w_CLK),
        .rst        (w_RST),
        .o_digit    (w_digit),
        .o_blackout (w_blackout),
        .o_boundary (w_boundary)
    );

    assign w_kcRise   = bus.w_KC & ~r_kcPrev;
    assign w_instrEnd = w_boundary && (r_stage == ACTION2) && (r_state != STOPPED);

    always_ff @(posedge w_CLK or posedge w_RST) begin
        if (w_RST) begin
            r_state  <= STOPPED;
            r_stage  <= SCAN1;
            r_halt   <= 1'b1;
            r_pend   <= 1'b0;
            r_kcPrev <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_stage  <= w_stageNext;
            r_halt   <= w_haltNext;
            r_pend   <= w_pendNext;
            r_kcPrev <= bus.w_KC;
        end
    end

    // Run state and stage only move at the beat boundary; an instruction always completes.
    always_comb begin
        w_stateNext = r_state;
        w_stageNext = r_stage;
        w_haltNext  = r_halt;
        w_pendNext  = r_pend;

        case (r_state)
            STOPPED: begin
                w_stageNext = SCAN1;
                if (w_boundary) begin
                    if (bus.w_RUN_SWITCH && !r_halt) begin
                        w_stateNext = RUNNING;
                    end else if (r_pend) begin
                        w_stateNext = SINGLE;
                    end
                end
            end
            RUNNING: begin
                if (w_boundary) begin
                    w_stageNext = stage_t'(r_stage + 2'd1);
                    if (w_instrEnd && (bus.w_STOP_INSTR || !bus.w_RUN_SWITCH)) begin
                        w_stateNext = STOPPED;
                    end
                end
            end
            SINGLE: begin
                if (w_boundary) begin
                    w_stageNext = stage_t'(r_stage + 2'd1);
                    if (w_instrEnd) begin
                        w_stateNext = STOPPED;
                    end
                end
            end
            default: begin
                w_stateNext = STOPPED;
                w_stageNext = SCAN1;
            end
        endcase

        // Switch low wins over a simultaneous STOP, so the operator can always restart.
        if (w_instrEnd && bus.w_STOP_INSTR) begin
            w_haltNext = 1'b1;
        end
        if (!bus.w_RUN_SWITCH) begin
            w_haltNext = 1'b0;
        end

        if (w_kcRise && (r_state == STOPPED) && !bus.w_RUN_SWITCH) begin
            w_pendNext = 1'b1;
        end
        if ((r_state == STOPPED) && (w_stateNext == SINGLE)) begin
            w_pendNext = 1'b0;
        end
    end

    assign bus.w_DIGIT          = w_digit;
    assign bus.w_BLACKOUT       = w_blackout;
    assign bus.w_STAGE          = r_stage;
    assign bus.w_PARA_ACTION_WF = (r_stage == SCAN1) || (r_stage == SCAN2);
    assign bus.w_ACTION_PARA_WF = !((r_stage == SCAN1) || (r_stage == SCAN2));
    assign bus.w_INSTR_GATE     = !((r_stage == ACTION1) && !w_blackout);
    assign bus.w_ACTION_TRIGGER = w_boundary && (r_state != STOPPED) &&
                                  ((r_stage == SCAN1) || (r_stage == SCAN2));
    assign bus.w_RUNNING        = (r_state != STOPPED);

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: a digit/beat/run-mode reference model
// predicts every output each cycle while scenarios and random panel activity run.
module tb_beat_sequencer;

    localparam int BEAT = 36;
    localparam int WORD = 32;
    localparam int INSTR = 4 * BEAT;
    localparam logic [13:0] RESET_VEC = {6'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;
    bit   stopAtEnd = 1'b0;

    int mDigit, mStage, mMode;
    bit mHalt, mPend, mKcPrev;

    beat_sequencer_if bus ();

    beat_sequencer dut (
        .w_CLK (clock),
        .w_RST (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [13:0] obsVec();
        return {bus.w_DIGIT, bus.w_BLACKOUT, bus.w_STAGE, bus.w_PARA_ACTION_WF,
                bus.w_ACTION_PARA_WF, bus.w_INSTR_GATE, bus.w_ACTION_TRIGGER, bus.w_RUNNING};
    endfunction

    function automatic logic [13:0] expVec();
        logic scan, gate, trig;
        scan = (mStage % 2) == 0;
        gate = !(mStage == 1 && mDigit < WORD);
        trig = (mMode != 0) && (mDigit == BEAT - 1) && scan;
        return {6'(mDigit), 1'(mDigit >= WORD), 2'(mStage), scan, !scan, gate, trig, 1'(mMode != 0)};
    endfunction

    task automatic modelReset();
        mDigit = 0; mStage = 0; mMode = 0;
        mHalt = 1'b1; mPend = 1'b0; mKcPrev = 1'b0;
    endtask

    // Applies the run-control rules for one digit period with the inputs seen at the edge.
    task automatic modelUpdate(input bit sw, input bit kc, input bit stop);
        bit boundary, newHalt, newPend;
        int newMode, newStage;
        boundary = (mDigit == BEAT - 1);
        newMode  = mMode;
        newStage = mStage;
        newHalt  = mHalt;
        newPend  = mPend;
        if (boundary && mMode != 0 && mStage == 3 && stop) newHalt = 1'b1;
        if (!sw) newHalt = 1'b0;
        if (kc && !mKcPrev && mMode == 0 && !sw) newPend = 1'b1;
        if (boundary) begin
            if (mMode == 0) begin
                newStage = 0;
                if (sw && !mHalt) newMode = 1;
                else if (mPend) begin
                    newMode = 2;
                    newPend = 1'b0;
                end
            end else begin
                newStage = (mStage + 1) % 4;
                if (mStage == 3 && (mMode == 2 || stop || !sw)) newMode = 0;
            end
        end
        mDigit  = (mDigit + 1) % BEAT;
        mStage  = newStage;
        mMode   = newMode;
        mHalt   = newHalt;
        mPend   = newPend;
        mKcPrev = kc;
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) modelReset();
        else modelUpdate(bus.w_RUN_SWITCH, bus.w_KC, bus.w_STOP_INSTR);
        cycle++;
        #1;
        if (mMode != 0 && mStage == 3 && mDigit == BEAT - 1) bus.w_STOP_INSTR = stopAtEnd;
        else bus.w_STOP_INSTR = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        bus.w_RUN_SWITCH = 1'b1;
        bus.w_KC = 1'b0;
        bus.w_STOP_INSTR = 1'b0;
        #2;
        total++;
        if (obsVec() !== RESET_VEC) begin
            bad++;
            $display("[TB] FAIL reset_initial: got %h want %h", obsVec(), RESET_VEC);
        end
        step();
        total++;
        if (obsVec() !== RESET_VEC) begin
            bad++;
            $display("[TB] FAIL reset_held: got %h want %h", obsVec(), RESET_VEC);
        end
        reset = 1'b0;
    endtask

    task automatic test_stopped_hold();
        int trigs = 0;
        bus.w_RUN_SWITCH = 1'b1;
        repeat (3 * BEAT) begin
            step();
            if (bus.w_ACTION_TRIGGER === 1'b1) trigs++;
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL stopped_hold cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
        end
        total++;
        if (trigs !== 0) begin
            bad++;
            $display("[TB] FAIL stopped_no_trigger: got %0d pulses want 0", trigs);
        end
    endtask

    task automatic test_run_start();
        int trigs = 0;
        bus.w_RUN_SWITCH = 1'b0;
        step();
        bus.w_RUN_SWITCH = 1'b1;
        repeat (2 * INSTR + BEAT) begin
            step();
            if (bus.w_ACTION_TRIGGER === 1'b1) trigs++;
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL run_start cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
        end
        total++;
        if (bus.w_RUNNING !== 1'b1 || trigs < 4) begin
            bad++;
            $display("[TB] FAIL run_start_running: got running=%b trig=%0d want running=1 trig>=4",
                     bus.w_RUNNING, trigs);
        end
    endtask

    task automatic test_stop_instr();
        int budget = 2 * INSTR;
        stopAtEnd = 1'b1;
        while (mMode != 0 && budget > 0) begin
            step();
            budget--;
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL stop_instr cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
        end
        stopAtEnd = 1'b0;
        total++;
        if (budget == 0) begin
            bad++;
            $display("[TB] FAIL stop_instr_timeout: got no stop within %0d cycles want stop", 2 * INSTR);
        end
        repeat (2 * BEAT) begin
            step();
            total++;
            if (obsVec() !== expVec() || bus.w_RUNNING !== 1'b0) begin
                bad++;
                $display("[TB] FAIL halted_hold cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
        end
        bus.w_RUN_SWITCH = 1'b0;
        step();
        bus.w_RUN_SWITCH = 1'b1;
        repeat (INSTR + BEAT) begin
            step();
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL restart cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
        end
    endtask

    task automatic test_switch_drop();
        int budget = 2 * INSTR;
        while (!(mMode == 1 && mStage == 2) && budget > 0) begin
            step();
            budget--;
        end
        repeat ($urandom_range(0, 30)) step();
        bus.w_RUN_SWITCH = 1'b0;
        budget = 2 * INSTR;
        while (mMode != 0 && budget > 0) begin
            step();
            budget--;
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL switch_drop cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
        end
        total++;
        if (budget == 0 || bus.w_STAGE !== 2'd0) begin
            bad++;
            $display("[TB] FAIL switch_drop_stop: got stage=%0d budget=%0d want stage=0 budget>0",
                     bus.w_STAGE, budget);
        end
    endtask

    task automatic test_single_shot();
        int runCycles = 0;
        int budget = 3 * INSTR;
        bus.w_RUN_SWITCH = 1'b0;
        repeat ($urandom_range(1, 20)) step();
        bus.w_KC = 1'b1;
        repeat ($urandom_range(1, 5)) step();
        bus.w_KC = 1'b0;
        while (runCycles < INSTR + 2 * BEAT && budget > 0) begin
            step();
            budget--;
            if (bus.w_RUNNING === 1'b1) runCycles++;
            if (runCycles == 50) bus.w_KC = 1'b1;
            if (runCycles == 55) bus.w_KC = 1'b0;
            if (runCycles > 0 && mMode == 0 && bus.w_RUNNING === 1'b0 && runCycles >= INSTR)
                budget = (budget > 2 * BEAT) ? 2 * BEAT : budget;
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL single_shot cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
        end
        bus.w_KC = 1'b0;
        total++;
        if (runCycles !== INSTR) begin
            bad++;
            $display("[TB] FAIL single_length: got %0d running cycles want %0d", runCycles, INSTR);
        end
    endtask

    task automatic test_reset_midbeat();
        int budget = 3 * INSTR;
        bus.w_RUN_SWITCH = 1'b0;
        step();
        bus.w_RUN_SWITCH = 1'b1;
        while (!(mMode == 1 && mStage == 1 && mDigit == 17) && budget > 0) begin
            step();
            budget--;
        end
        total++;
        if (budget == 0) begin
            bad++;
            $display("[TB] FAIL reset_mid_reach: got timeout want ACTION1 digit 17");
        end
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        total++;
        if (obsVec() !== RESET_VEC) begin
            bad++;
            $display("[TB] FAIL reset_midbeat: got %h want %h", obsVec(), RESET_VEC);
        end
        step();
        reset = 1'b0;
        repeat (BEAT + 4) begin
            step();
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL after_reset cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
        end
    endtask

    task automatic test_random();
        repeat (1500) begin
            if ($urandom_range(0, 99) < 3) bus.w_RUN_SWITCH = ~bus.w_RUN_SWITCH;
            if ($urandom_range(0, 99) < 5) bus.w_KC = ~bus.w_KC;
            if (mDigit == 0) stopAtEnd = ($urandom_range(0, 9) < 2);
            step();
            total++;
            if (obsVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL random cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
        end
    endtask

    initial begin
        modelReset();
        $display("[TB] beat_sequencer bench start");
        test_reset();
        test_stopped_hold();
        test_run_start();
        test_stop_instr();
        test_switch_drop();
        test_single_shot();
        test_reset_midbeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Master timing and run-control sequencer for the SSEM datapath. Counts digit periods within a beat and steps each instruction through the four beats SCAN1, ACTION1, SCAN2, ACTION2. Generates the beat-level waveforms that the transfer gates, S-erase generator, instruction gate and test unit consume. Implements operator stop/run and single-shot (KC) control, and halts on a decoded STOP instruction.

## Interface
- WORD_BITS, 32, data digits per beat
- BLACKOUT_BITS, 4, blackout digits per beat; BEAT_LEN = WORD_BITS + BLACKOUT_BITS
- w_CLK  in  1  digit clock; one cycle = one digit period
- w_RST  in  1  reset, asynchronous, active-high
- w_RUN_SWITCH  in  1  operator stop/run switch level (1 = run)
- w_KC  in  1  single-shot key, level; only the rising edge is used
- w_STOP_INSTR  in  1  decoded STOP from the staticisor; valid at the final digit of ACTION2
- w_DIGIT  out  $clog2(BEAT_LEN)  digit number within the beat, 0..BEAT_LEN-1
- w_BLACKOUT  out  1  high for digits WORD_BITS..BEAT_LEN-1
- w_STAGE  out  2  current beat: SCAN1=0, ACTION1=1, SCAN2=2, ACTION2=3
- w_PARA_ACTION_WF  out  1  high in scan beats and while stopped; low in action beats
- w_ACTION_PARA_WF  out  1  exact complement of w_PARA_ACTION_WF
- w_INSTR_GATE  out  1  low only on non-blackout digits of ACTION1, so the instruction gate passes the control line; high otherwise
- w_ACTION_TRIGGER  out  1  one-cycle pulse on the last digit of a scan beat that is followed by an action beat
- w_RUNNING  out  1  high in RUNNING or SINGLE

## Operation
- Digit counter: free-runs 0..BEAT_LEN-1 and wraps in every run state. It also runs while stopped, so store refresh continues. The beat boundary is digit BEAT_LEN-1.
- Run states: STOPPED, RUNNING, SINGLE. All state and stage changes happen only at a beat boundary.
- Halt latch H: set at the end of ACTION2 when w_STOP_INSTR=1. Cleared on any clock where w_RUN_SWITCH=0. Reset value 1, so the operator must cycle the switch after reset.
- KC pending P: set by a rising edge of w_KC while STOPPED and w_RUN_SWITCH=0. Ignored otherwise. Cleared when SINGLE is entered.
- STOPPED: stage held at SCAN1, w_ACTION_TRIGGER suppressed. At a boundary:
  - w_RUN_SWITCH=1 and H=0 → RUNNING.
  - Otherwise, if P=1 → SINGLE.
  - The next beat is SCAN1.
- RUNNING: stage advances SCAN1→ACTION1→SCAN2→ACTION2→SCAN1. At the end of ACTION2, w_STOP_INSTR=1 or w_RUN_SWITCH=0 → STOPPED. An instruction is never abandoned mid-way.
- SINGLE: runs exactly one four-beat instruction, then → STOPPED at the end of ACTION2. w_STOP_INSTR still sets H.
- Simultaneous events at the ACTION2 end: STOP and switch-low both give STOPPED. H is then set but immediately cleared by switch low.
- Reset: asynchronous, effective mid-beat. Reset values:
  - Outputs: w_DIGIT=0, w_BLACKOUT=0, w_STAGE=SCAN1, w_PARA_ACTION_WF=1, w_ACTION_PARA_WF=0, w_INSTR_GATE=1, w_ACTION_TRIGGER=0, w_RUNNING=0.
  - Internal: state STOPPED, H=1, P=0, KC edge register=0.

## Timing
- All outputs are registered or decoded from registers; no combinational path from inputs to outputs.
- Beat = BEAT_LEN cycles (36 by default); instruction = 4·BEAT_LEN cycles (144 by default).
- w_ACTION_TRIGGER pulses at cycle BEAT_LEN-1 of SCAN1 and of SCAN2, only when running.
- Waveform transitions (PARA/ACTION, INSTR_GATE) are coincident with the w_DIGIT wrap to 0.
- w_KC edge: registered one cycle, then P set. The switch is sampled each clock. Run-state latency to the following beat boundary is up to BEAT_LEN cycles.
- w_STOP_INSTR is sampled only at digit BEAT_LEN-1 of ACTION2 and ignored elsewhere.

## Structure
- Shared package beat_pkg holds:
  - stage encodings SCAN1/ACTION1/SCAN2/ACTION2
  - run-state encodings STOPPED/RUNNING/SINGLE
  - BEAT_LEN derivation function
- Sub-module digit_counter: modulo-BEAT_LEN counter with async reset. Outputs the count, w_BLACKOUT and a boundary strobe.
- beat_sequencer holds the stage register, run FSM, H, P and the waveform decode.

## Test plan
- Reset, then w_RUN_SWITCH=1 held → stays STOPPED indefinitely (H=1); w_DIGIT wraps 35→0; w_PARA_ACTION_WF=1; no w_ACTION_TRIGGER.
- Switch 0 for 1 cycle, then 1 → RUNNING at the next boundary. Stages run 0,1,2,3 at 36 cycles each. w_ACTION_TRIGGER pulses exactly at digit 35 of stages 0 and 2. w_INSTR_GATE is low for digits 0..31 of ACTION1 only.
- While RUNNING, w_STOP_INSTR=1 at digit 35 of ACTION2 → STOPPED next beat. Switch held high → remains stopped. Switch 0→1 → restarts.
- Switch 0 while stopped, pulse w_KC → exactly one 144-cycle instruction with w_RUNNING=1, then STOPPED. A second KC edge during SINGLE is ignored.
- Switch dropped to 0 during SCAN2 → current instruction completes through ACTION2, then STOPPED.
- Assert w_RST at digit 17 of ACTION1 → all outputs take reset values immediately. Release → counting restarts from digit 0 in STOPPED.
